// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD read and write sequencers:
// state codes, register-select codes and default bus timing.
package lcd_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_E_HIGH  = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    localparam logic RS_INSTR = 1'b0;
    localparam logic RS_DATA  = 1'b1;

    // Defaults at 50 MHz
    localparam int unsigned LCD_SETUP_CYCLES   = 3;
    localparam int unsigned LCD_E_HIGH_CYCLES  = 12;
    localparam int unsigned LCD_HOLD_CYCLES    = 2;
    localparam int unsigned LCD_RECOVER_CYCLES = 25;
    localparam logic [15:0] LCD_POLL_LIMIT     = 16'd2000;

    localparam int unsigned LCD_BF_BIT = 7;

    // Timer reload value for a state lasting n clocks
    function automatic logic [7:0] cyc_load(input int unsigned n);
        return 8'(n - 1);
    endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Load/expire down-counter used to time LCD bus phases; done is high
// while the count is zero.
module lcd_cycle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    output logic       done
);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign done = (r_count == '0);

endmodule

// File: rtl/lcd_read_ctrl.sv
// HD44780 read-cycle sequencer: returns the BF/AC byte or a RAM byte, and
// can repeat BF reads until the controller is no longer busy.
module lcd_read_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES   = LCD_SETUP_CYCLES,
    parameter int unsigned E_HIGH_CYCLES  = LCD_E_HIGH_CYCLES,
    parameter int unsigned HOLD_CYCLES    = LCD_HOLD_CYCLES,
    parameter int unsigned RECOVER_CYCLES = LCD_RECOVER_CYCLES,
    parameter logic [15:0] POLL_LIMIT     = LCD_POLL_LIMIT
) (
    input  logic       CLK_50MHZ,
    input  logic       BTN_SOUTH,
    input  logic       rd_req,
    input  logic       rd_rs,
    input  logic       rd_poll,
    output logic       rd_busy,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       rd_bf,
    output logic [6:0] rd_ac,
    output logic       rd_timeout,
    input  logic [7:0] LCD_DB_IN,
    output logic       LCD_DB_OE,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW
);

    logic [2:0]  r_state;
    logic        r_rs;
    logic        r_poll;
    logic [15:0] r_poll_cnt;
    logic        r_busy;
    logic        r_valid;
    logic [7:0]  r_data;
    logic        r_timeout;
    logic        r_e;
    logic        r_lcd_rs;
    logic        r_rw;
    logic        r_oe;

    logic        w_done;
    logic        w_load;
    logic [7:0]  w_value;
    logic        w_accept;
    logic        w_bf_set;
    logic        w_repoll;
    logic        w_limit_hit;

    lcd_cycle_timer u_timer (
        .clk   (CLK_50MHZ),
        .rst   (BTN_SOUTH),
        .load  (w_load),
        .value (w_value),
        .done  (w_done)
    );

    // r_busy still high in the rd_valid cycle blocks a same-cycle accept
    assign w_accept    = (r_state == ST_IDLE) && rd_req && !r_busy;
    assign w_bf_set    = r_data[LCD_BF_BIT];
    assign w_repoll    = r_poll && w_bf_set && (r_poll_cnt < POLL_LIMIT);
    assign w_limit_hit = r_poll && w_bf_set && (r_poll_cnt >= POLL_LIMIT);

    always_comb begin
        w_load  = 1'b0;
        w_value = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load  = 1'b1;
                    w_value = cyc_load(SETUP_CYCLES);
                end
            end
            ST_SETUP: begin
                if (w_done) begin
                    w_load  = 1'b1;
                    w_value = cyc_load(E_HIGH_CYCLES);
                end
            end
            ST_E_HIGH: begin
                if (w_done) begin
                    w_load  = 1'b1;
                    w_value = cyc_load(HOLD_CYCLES);
                end
            end
            ST_HOLD: begin
                if (w_done) begin
                    w_load  = 1'b1;
                    w_value = cyc_load(RECOVER_CYCLES);
                end
            end
            ST_RECOVER: begin
                if (w_done && w_repoll) begin
                    w_load  = 1'b1;
                    w_value = cyc_load(SETUP_CYCLES);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_50MHZ or posedge BTN_SOUTH) begin
        if (BTN_SOUTH) begin
            r_state    <= ST_IDLE;
            r_rs       <= RS_INSTR;
            r_poll     <= 1'b0;
            r_poll_cnt <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_timeout  <= 1'b0;
            r_e        <= 1'b0;
            r_lcd_rs   <= RS_INSTR;
            r_rw       <= 1'b0;
            r_oe       <= 1'b1;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rs       <= rd_rs;
                        r_poll     <= rd_poll;
                        r_poll_cnt <= '0;
                        r_timeout  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_rw       <= 1'b1;
                        r_lcd_rs   <= rd_rs;
                        r_oe       <= 1'b0;
                        r_state    <= ST_SETUP;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (w_done) begin
                        r_e     <= 1'b1;
                        r_state <= ST_E_HIGH;
                    end
                end
                ST_E_HIGH: begin
                    if (w_done) begin
                        r_e    <= 1'b0;
                        r_data <= LCD_DB_IN;
                        if (r_poll_cnt != '1) begin
                            r_poll_cnt <= r_poll_cnt + 16'd1;
                        end
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_done) begin
                        r_rw     <= 1'b0;
                        r_lcd_rs <= RS_INSTR;
                        r_state  <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    // OE goes high after the first recover clock so RW=0 leads the drive
                    if (!w_done) begin
                        r_oe <= 1'b1;
                    end else if (w_repoll) begin
                        r_rw     <= 1'b1;
                        r_lcd_rs <= r_rs;
                        r_oe     <= 1'b0;
                        r_state  <= ST_SETUP;
                    end else begin
                        r_valid   <= 1'b1;
                        r_timeout <= w_limit_hit;
                        r_oe      <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_busy    = r_busy;
    assign rd_valid   = r_valid;
    assign rd_data    = r_data;
    assign rd_timeout = r_timeout;
    assign rd_bf      = (r_rs == RS_INSTR) ? r_data[LCD_BF_BIT] : 1'b0;
    assign rd_ac      = (r_rs == RS_INSTR) ? r_data[6:0] : 7'd0;
    assign LCD_DB_OE  = r_oe;
    assign LCD_E      = r_e;
    assign LCD_RS     = r_lcd_rs;
    assign LCD_RW     = r_rw;

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Directed bench for lcd_read_ctrl with an LCD read-response model and a
// scoreboard of expected results per request.
module tb_lcd_read_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd_req = 1'b0;
    logic       rd_rs = 1'b0;
    logic       rd_poll = 1'b0;
    logic       rd_busy, rd_valid, rd_bf, rd_timeout;
    logic [7:0] rd_data;
    logic [6:0] rd_ac;
    logic [7:0] db_in;
    logic       lcd_oe, lcd_e, lcd_rs, lcd_rw;

    always #10 clk = ~clk;

    lcd_read_ctrl #(.POLL_LIMIT(16'd5)) dut (
        .CLK_50MHZ  (clk),
        .BTN_SOUTH  (rst),
        .rd_req     (rd_req),
        .rd_rs      (rd_rs),
        .rd_poll    (rd_poll),
        .rd_busy    (rd_busy),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_bf      (rd_bf),
        .rd_ac      (rd_ac),
        .rd_timeout (rd_timeout),
        .LCD_DB_IN  (db_in),
        .LCD_DB_OE  (lcd_oe),
        .LCD_E      (lcd_e),
        .LCD_RS     (lcd_rs),
        .LCD_RW     (lcd_rw)
    );

    typedef struct {
        logic [7:0] data;
        logic       bf;
        logic [6:0] ac;
        logic       tmo;
        int         lat;
        int         pulses;
        int         ecyc;
        int         rw;
        int         rs_c;
        int         oe_low;
        int         req_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e_pulses = 0, e_cycles = 0, rw_cycles = 0, rs_cycles = 0, oe_low_cycles = 0;
    int valid_count = 0, contention = 0;
    logic [7:0] model_byte = 8'h00;
    logic [7:0] resp[$] = '{8'h00};

    // LCD model: presents the current response byte only while E is high
    assign db_in = lcd_e ? model_byte : 8'h00;

    always @(posedge clk) cyc++;
    always @(posedge lcd_e) e_pulses++;
    always @(negedge lcd_e) begin
        if (resp.size() > 1) void'(resp.pop_front());
        model_byte = resp[0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic rs, input logic tmo, input int n);
        exp_t e;
        e.data    = d;
        e.bf      = rs ? 1'b0 : d[7];
        e.ac      = rs ? 7'd0 : d[6:0];
        e.tmo     = tmo;
        e.lat     = 1 + 42 * n;
        e.pulses  = n;
        e.ecyc    = 12 * n;
        e.rw      = 17 * n;
        e.rs_c    = rs ? 17 * n : 0;
        e.oe_low  = 18 * n;
        e.req_cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (lcd_e) e_cycles++;
            if (lcd_rw) rw_cycles++;
            if (lcd_rs) rs_cycles++;
            if (!lcd_oe) oe_low_cycles++;
            if (lcd_oe && (lcd_rw || lcd_e)) contention++;
            if (rd_valid) begin
                valid_count++;
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    got_e = sb.pop_front();
                    check("data", rd_data, got_e.data);
                    check("bf", rd_bf, got_e.bf);
                    check("ac", rd_ac, got_e.ac);
                    check("timeout", rd_timeout, got_e.tmo);
                    check("latency", cyc - got_e.req_cyc, got_e.lat);
                    check("e_pulses", e_pulses, got_e.pulses);
                    check("e_high_cycles", e_cycles, got_e.ecyc);
                    check("rw_cycles", rw_cycles, got_e.rw);
                    check("rs_cycles", rs_cycles, got_e.rs_c);
                    check("oe_low_cycles", oe_low_cycles, got_e.oe_low);
                    check("busy_at_valid", rd_busy, 1);
                end
            end
        end
    end

    task automatic set_model(input logic [7:0] final_byte, input int nbusy);
        resp.delete();
        repeat (nbusy) resp.push_back(8'h80);
        resp.push_back(final_byte);
        model_byte = resp[0];
    endtask

    task automatic do_req(input logic rs, input logic poll, input exp_t e, input bit sync);
        if (sync) @(negedge clk);
        #1;
        rd_req = 1'b1;
        rd_rs = rs;
        rd_poll = poll;
        e_pulses = 0; e_cycles = 0; rw_cycles = 0; rs_cycles = 0; oe_low_cycles = 0;
        e.req_cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        check("busy_accept", rd_busy, 1);
        check("tmo_clear_accept", rd_timeout, 0);
        #1;
        rd_req = 1'b0;
        rd_rs = 1'b0;
        rd_poll = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int start;
        int n;
        start = valid_count;
        n = 0;
        while (valid_count == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("valid_seen", 32'(valid_count != start), 1);
        @(negedge clk);
        check("busy_drop", rd_busy, 0);
        check("valid_single", rd_valid, 0);
    endtask

    initial begin
        int vc;
        int n;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_e", lcd_e, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_rw", lcd_rw, 0);
        check("rst_oe", lcd_oe, 1);
        check("rst_busy", rd_busy, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_tmo", rd_timeout, 0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single BF/AC read
        set_model(8'h25, 0);
        do_req(1'b0, 1'b0, mk(8'h25, 1'b0, 1'b0, 1), 1'b1);
        wait_valid(100);

        // Data RAM read, requested in the cycle busy drops
        set_model(8'h41, 0);
        do_req(1'b1, 1'b0, mk(8'h41, 1'b1, 1'b0, 1), 1'b0);
        wait_valid(100);

        // Busy poll: three busy reads then ready
        set_model(8'h12, 3);
        do_req(1'b0, 1'b1, mk(8'h12, 1'b0, 1'b0, 4), 1'b1);
        wait_valid(300);

        // Request while busy must be ignored
        set_model(8'h3C, 0);
        do_req(1'b0, 1'b0, mk(8'h3C, 1'b0, 1'b0, 1), 1'b1);
        repeat (10) @(negedge clk);
        #1 rd_req = 1'b1; rd_rs = 1'b1;
        @(negedge clk);
        #1 rd_req = 1'b0; rd_rs = 1'b0;
        wait_valid(100);
        vc = valid_count;
        repeat (60) @(negedge clk);
        check("no_extra_valid", valid_count, vc);
        check("no_extra_e", e_pulses, 1);

        // Poll timeout with BF stuck high
        set_model(8'hFF, 0);
        do_req(1'b0, 1'b1, mk(8'hFF, 1'b0, 1'b1, 5), 1'b1);
        wait_valid(400);
        repeat (5) @(negedge clk);
        check("tmo_held", rd_timeout, 1);
        check("bf_held", rd_bf, 1);

        // Next request clears the timeout
        set_model(8'h25, 0);
        do_req(1'b0, 1'b0, mk(8'h25, 1'b0, 1'b0, 1), 1'b1);
        wait_valid(100);

        // Reset in the middle of E high
        set_model(8'h66, 0);
        do_req(1'b0, 1'b0, mk(8'h66, 1'b0, 1'b0, 1), 1'b1);
        n = 0;
        while (!lcd_e && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("e_reached", lcd_e, 1);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_e", lcd_e, 0);
        check("abort_rw", lcd_rw, 0);
        check("abort_rs", lcd_rs, 0);
        check("abort_oe", lcd_oe, 1);
        check("abort_busy", rd_busy, 0);
        check("abort_valid", rd_valid, 0);
        check("abort_data", rd_data, 0);
        sb.delete();
        vc = valid_count;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (50) @(negedge clk);
        check("no_valid_after_abort", valid_count, vc);

        set_model(8'h5A, 0);
        do_req(1'b0, 1'b0, mk(8'h5A, 1'b0, 1'b0, 1), 1'b1);
        wait_valid(100);

        check("bus_contention", contention, 0);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
